// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule feeder: loads one 512-bit block, then streams W0..W63
// with the matching round constants K0..K63, one pair per cycle, to the compression stage.
module sha256_msg_schedule (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [511:0] block_in,
    output logic [31:0]  w_out,
    output logic [31:0]  k_out,
    output logic         round_en,
    output logic [5:0]   round_idx,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [31:0] w_new;

    // Small sigma functions of the message expansion.
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    // Round-constant ROM: first 32 bits of the fractional parts of the cube roots of
    // the first 64 primes.
    function automatic logic [31:0] k_rom(input logic [5:0] idx);
        logic [31:0] k;
        k = '0;
        case (idx)
            6'd0:  k = 32'h428a2f98;
            6'd1:  k = 32'h71374491;
            6'd2:  k = 32'hb5c0fbcf;
            6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;
            6'd5:  k = 32'h59f111f1;
            6'd6:  k = 32'h923f82a4;
            6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;
            6'd9:  k = 32'h12835b01;
            6'd10: k = 32'h243185be;
            6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;
            6'd13: k = 32'h80deb1fe;
            6'd14: k = 32'h9bdc06a7;
            6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;
            6'd17: k = 32'hefbe4786;
            6'd18: k = 32'h0fc19dc6;
            6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;
            6'd21: k = 32'h4a7484aa;
            6'd22: k = 32'h5cb0a9dc;
            6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;
            6'd25: k = 32'ha831c66d;
            6'd26: k = 32'hb00327c8;
            6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;
            6'd29: k = 32'hd5a79147;
            6'd30: k = 32'h06ca6351;
            6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;
            6'd33: k = 32'h2e1b2138;
            6'd34: k = 32'h4d2c6dfc;
            6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;
            6'd37: k = 32'h766a0abb;
            6'd38: k = 32'h81c2c92e;
            6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;
            6'd41: k = 32'ha81a664b;
            6'd42: k = 32'hc24b8b70;
            6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;
            6'd45: k = 32'hd6990624;
            6'd46: k = 32'hf40e3585;
            6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;
            6'd49: k = 32'h1e376c08;
            6'd50: k = 32'h2748774c;
            6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;
            6'd53: k = 32'h4ed8aa4a;
            6'd54: k = 32'h5b9cca4f;
            6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;
            6'd57: k = 32'h78a5636f;
            6'd58: k = 32'h84c87814;
            6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;
            6'd61: k = 32'ha4506ceb;
            6'd62: k = 32'hbef9a3f7;
            6'd63: k = 32'hc67178f2;
            default: k = '0;
        endcase
        return k;
    endfunction

    // Next schedule word W_{t+16} from the current window (single-cycle adder tree).
    always_comb begin
        w_new = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
    end

    // Next-state logic: capture on start in idle, slide the window every run cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = 6'd0;
                    for (int j = 0; j < 16; j++) begin
                        win_d[j] = block_in[511 - 32*j -: 32];
                    end
                end
            end
            StRun: begin
                for (int j = 0; j < 15; j++) begin
                    win_d[j] = win_q[j+1];
                end
                win_d[15] = w_new;
                cnt_d     = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counter and window registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
            for (int j = 0; j < 16; j++) begin
                win_q[j] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int j = 0; j < 16; j++) begin
                win_q[j] <= win_d[j];
            end
        end
    end

    // Outputs decoded purely from registered state; zero outside the run.
    always_comb begin
        w_out     = 32'd0;
        k_out     = 32'd0;
        round_en  = 1'b0;
        round_idx = 6'd0;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        if (state_q == StRun) begin
            w_out     = win_q[0];
            k_out     = k_rom(cnt_q);
            round_en  = 1'b1;
            round_idx = cnt_q;
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: a per-cycle expected timeline queue is filled
// whenever a start is expected to be accepted and drained one entry per cycle.
module tb_sha256_msg_schedule;

    logic         clk;
    logic         n_rst;
    logic         start;
    logic [511:0] block_in;
    logic [31:0]  w_out;
    logic [31:0]  k_out;
    logic         round_en;
    logic [5:0]   round_idx;
    logic         busy;
    logic         done;

    sha256_msg_schedule dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .block_in  (block_in),
        .w_out     (w_out),
        .k_out     (k_out),
        .round_en  (round_en),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [31:0] w;
        logic [31:0] k;
        logic [5:0]  idx;
        logic        busy;
        logic        done;
    } rec_t;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    rec_t        exp_q [$];
    logic [31:0] mw [64];
    logic [31:0] obs_w [64];
    logic [31:0] obs_k [64];
    int          vectors;
    int          errors;
    int          en_cnt;
    bit          cur_idle;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference message expansion.
    task automatic sched(input logic [511:0] b);
        for (int t = 0; t < 16; t++) mw[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            mw[t] = (rotr(mw[t-2], 17) ^ rotr(mw[t-2], 19) ^ (mw[t-2] >> 10))
                  + mw[t-7]
                  + (rotr(mw[t-15], 7) ^ rotr(mw[t-15], 18) ^ (mw[t-15] >> 3))
                  + mw[t-16];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_run(input logic [511:0] b);
        rec_t r;
        sched(b);
        for (int t = 0; t < 64; t++) begin
            r = '{en: 1'b1, w: mw[t], k: KT[t], idx: 6'(t), busy: 1'b1, done: 1'b0};
            exp_q.push_back(r);
        end
        r = '{en: 1'b0, w: 32'd0, k: 32'd0, idx: 6'd0, busy: 1'b1, done: 1'b1};
        exp_q.push_back(r);
    endtask

    task automatic chk_rec(input rec_t e);
        chk("round_en", {31'd0, round_en}, {31'd0, e.en});
        chk("w_out", w_out, e.w);
        chk("k_out", k_out, e.k);
        chk("round_idx", {26'd0, round_idx}, {26'd0, e.idx});
        chk("busy", {31'd0, busy}, {31'd0, e.busy});
        chk("done", {31'd0, done}, {31'd0, e.done});
    endtask

    // One clock: register an accepted start, then compare outputs at the falling edge.
    task automatic tick();
        rec_t e;
        if (start && cur_idle) push_run(block_in);
        @(negedge clk);
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        cur_idle = !e.busy;
        chk_rec(e);
        if (round_en) begin
            obs_w[round_idx] = w_out;
            obs_k[round_idx] = k_out;
            en_cnt++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    logic [511:0] blk_b;

    initial begin
        vectors  = 0;
        errors   = 0;
        en_cnt   = 0;
        cur_idle = 1'b1;
        n_rst    = 1'b0;
        start    = 1'b0;
        block_in = '0;

        // Reset values while held in reset.
        @(negedge clk);
        chk_rec('0);
        n_rst = 1'b1;
        ticks(2);

        // Message "abc": directed known words and constants, handshake timing.
        block_in = {32'h61626380, 416'd0, 32'h00000000, 32'h00000018};
        start    = 1'b1;
        tick();
        start    = 1'b0;
        block_in = '0;
        en_cnt   = 1;
        ticks(65);
        chk("abc_w0", obs_w[0], 32'h61626380);
        chk("abc_w15", obs_w[15], 32'h00000018);
        chk("abc_w16", obs_w[16], 32'h61626380);
        chk("abc_w17", obs_w[17], 32'h000f0000);
        chk("abc_k0", obs_k[0], 32'h428a2f98);
        chk("abc_k63", obs_k[63], 32'hc67178f2);
        chk("abc_en_cycles", en_cnt, 64);
        ticks(2);

        // Start pulsed mid-run with a different block is ignored.
        block_in = rand_block();
        start    = 1'b1;
        tick();
        start    = 1'b0;
        ticks(29);
        block_in = rand_block();
        start    = 1'b1;
        tick();
        start    = 1'b0;
        ticks(37);

        // Back-to-back runs with start held high.
        block_in = rand_block();
        start    = 1'b1;
        tick();
        blk_b    = rand_block();
        block_in = blk_b;
        ticks(66);
        start    = 1'b0;
        ticks(66);
        chk("b2b_second_w0", obs_w[0], blk_b[511:480]);

        // Full random schedule, then asynchronous reset at round 20.
        for (int r = 0; r < 2; r++) begin
            block_in = rand_block();
            start    = 1'b1;
            tick();
            start    = 1'b0;
            ticks(66);
        end
        block_in = rand_block();
        start    = 1'b1;
        tick();
        start    = 1'b0;
        ticks(20);
        n_rst = 1'b0;
        #1;
        chk_rec('0);
        exp_q.delete();
        cur_idle = 1'b1;
        #2;
        n_rst  = 1'b1;
        en_cnt = 0;
        ticks(12);
        chk("post_reset_en_cycles", en_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
